// File: rtl/ws_stage.sv
// ws_stage -- write-back stage.
//
// Captures completed instructions from the registered execute-to-writeback
// bus into a small commit FIFO and drains it into the register-file write
// port whenever the port grants. Also drives a forwarding bus (youngest
// queued entry) back to execute, a ready signal for backpressure and a
// retired-instruction counter.
//
// Parameters:
//   DEPTH  commit FIFO entries (power of two, >= 2)
//   CNT_W  retired-instruction counter width
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   es_to_ws_valid  [0] instruction present, [1] execute not blocked
//   es_to_ws_bus    {gr_we[69], dest[68:64], result[63:32], pc[31:0]}
//   ws_ready        room guaranteed for one entry on the next cycle
//   rf_wr_ready     register-file write port granted this cycle
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   ws_forward_bus  {valid[38], we[37], dest[36:32], data[31:0]}
//   retire_cnt      retired-instruction count (wraps)
//
// Optional feature (macro WS_TRACE_EN): adds debug_wb_pc, debug_wb_rf_we,
// debug_wb_rf_wnum and debug_wb_rf_wdata, registered one cycle after each
// pop and zero otherwise.

module ws_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       es_to_ws_valid,
  input  logic [69:0]      es_to_ws_bus,
  output logic             ws_ready,
  input  logic             rf_wr_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [38:0]      ws_forward_bus,
  output logic [CNT_W-1:0] retire_cnt
`ifdef WS_TRACE_EN
  ,
  output logic [31:0]      debug_wb_pc,
  output logic             debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [69:0]      mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q;
  logic [CNT_W-1:0] retire_q, retire_d;

  logic        empty;
  logic        accept;
  logic        pop;
  logic [69:0] head_e;
  logic [69:0] young_e;

  always_comb begin
    empty   = (count_q == '0);
    // Upstream re-presents held instructions, so acceptance keys off the
    // ready value it actually saw last cycle, not the current one.
    accept  = (es_to_ws_valid == 2'b11) && ready_q;
    pop     = !empty && rf_wr_ready;
    head_e  = mem_q[head_q];
    young_e = mem_q[tail_q - PW'(1)];

    // Ignores a possible pop on purpose: ready must hold even if the
    // write port withholds its grant next cycle.
    ws_ready = (count_q + CW'(accept)) < CW'(DEPTH);

    head_d   = pop    ? head_q + PW'(1) : head_q;
    tail_d   = accept ? tail_q + PW'(1) : tail_q;
    count_d  = count_q + CW'(accept) - CW'(pop);
    retire_d = retire_q + CNT_W'(pop);

    rf_we    = pop && head_e[69] && (head_e[68:64] != '0);
    rf_waddr = empty ? '0 : head_e[68:64];
    rf_wdata = empty ? '0 : head_e[63:32];

    ws_forward_bus = empty ? '0
                   : {1'b1, young_e[69] && (young_e[68:64] != '0), young_e[68:32]};

    retire_cnt = retire_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      retire_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ready_q  <= ws_ready;
      retire_q <= retire_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (accept) mem_q[tail_q] <= es_to_ws_bus;
  end

`ifdef WS_TRACE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_we    <= 1'b0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (pop) begin
      debug_wb_pc       <= head_e[31:0];
      debug_wb_rf_we    <= rf_we;
      debug_wb_rf_wnum  <= head_e[68:64];
      debug_wb_rf_wdata <= head_e[63:32];
    end else begin
      debug_wb_pc       <= '0;
      debug_wb_rf_we    <= 1'b0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end
  end
`endif

endmodule
